// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// The master supplies operands and accepts results; the slave is the adder itself.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, op_sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/subtract: one GROUP-bit lookahead group is resolved per stage,
// WIDTH/GROUP stages feed an output register; valid/ready handshake with full backpressure.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int NS = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0 || NS < 1) begin : width_check_g
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP");
    end

    // Returns {group carry out, group sum}; each carry is a flat sum of P/G/cin products.
    function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] x,
                                                 input logic [GROUP-1:0] y,
                                                 input logic             ci);
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic [GROUP:0]   c;
        logic             term;
        p = x ^ y;
        g = x & y;
        c = '0;
        for (int i = 0; i <= GROUP; i++) begin
            term = ci;
            for (int k = 0; k < i; k++) term = term & p[k];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) term = term & p[k];
                c[i] = c[i] | term;
            end
        end
        return {c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    logic             stall;
    logic             out_valid_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    assign stall         = out_valid_reg & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;

    // Stage gi carries only the operand bits not yet consumed plus the low sum bits already done.
    genvar gi;
    for (gi = 0; gi < NS; gi++) begin : stage_g
        localparam int LO = gi * GROUP;

        logic                valid_reg;
        logic [WIDTH-1:LO]   a_reg;
        logic [WIDTH-1:LO]   b_reg;
        logic                carry_reg;
        logic [GROUP:0]      grp;
        logic [LO+GROUP-1:0] psum_next;

        assign grp = cla_group(a_reg[LO +: GROUP], b_reg[LO +: GROUP], carry_reg);

        if (gi == 0) begin : first_g
            assign psum_next = grp[GROUP-1:0];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                end else if (!stall) begin
                    valid_reg <= bus.in_valid;
                end
            end

            // Subtract is folded into the operands here: A + ~B + (cin ^ 1).
            always_ff @(posedge clk) begin
                if (!stall) begin
                    a_reg     <= bus.a;
                    b_reg     <= bus.op_sub ? ~bus.b : bus.b;
                    carry_reg <= bus.cin ^ bus.op_sub;
                end
            end
        end else begin : next_g
            logic [LO-1:0] psum_reg;

            assign psum_next = {grp[GROUP-1:0], psum_reg};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                end else if (!stall) begin
                    valid_reg <= stage_g[gi-1].valid_reg;
                end
            end

            always_ff @(posedge clk) begin
                if (!stall) begin
                    a_reg     <= stage_g[gi-1].a_reg[WIDTH-1:LO];
                    b_reg     <= stage_g[gi-1].b_reg[WIDTH-1:LO];
                    carry_reg <= stage_g[gi-1].grp[GROUP];
                    psum_reg  <= stage_g[gi-1].psum_next;
                end
            end
        end
    end

    logic             last_valid;
    logic [WIDTH-1:0] last_sum;
    logic             last_cout;
    logic             last_ovf;

    assign last_valid = stage_g[NS-1].valid_reg;
    assign last_sum   = stage_g[NS-1].psum_next;
    assign last_cout  = stage_g[NS-1].grp[GROUP];
    // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
    assign last_ovf   = last_sum[WIDTH-1] ^ stage_g[NS-1].a_reg[WIDTH-1]
                      ^ stage_g[NS-1].b_reg[WIDTH-1] ^ last_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else if (!stall) begin
            out_valid_reg <= last_valid;
            if (last_valid) begin
                sum_reg  <= last_sum;
                cout_reg <= last_cout;
                ovf_reg  <= last_ovf;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Random + directed bench for pipelined_cla_adder at WIDTH=16/GROUP=4 and WIDTH=32/GROUP=8,
// scored against a plain-arithmetic reference model.
module tb_pipelined_cla_adder;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   lat16 = 1'b0;
    exp_t q16[$];
    exp_t q32[$];
    exp_t m16;
    exp_t m32;

    pipelined_cla_adder_if #(.WIDTH(16)) bus16 ();
    pipelined_cla_adder_if #(.WIDTH(32)) bus32 ();

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // Reference: integer add/subtract, unsigned for sum/cout, signed range test for ovf.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic op);
        exp_t              e;
        longint unsigned   ua, ub, full, mask;
        longint            sa, sb, r, lim;
        ua   = 64'(a);
        ub   = 64'(b);
        mask = (64'd1 << w) - 64'd1;
        lim  = longint'(64'd1 << (w - 1));
        if (op) begin
            full   = ua - ub - 64'(cin);
            e.cout = (ua >= ub + 64'(cin));
        end else begin
            full   = ua + ub + 64'(cin);
            e.cout = ((full >> w) & 64'd1) != 0;
        end
        e.sum = 32'(full & mask);
        sa = a[w-1] ? longint'(ua) - 2 * lim : longint'(ua);
        sb = b[w-1] ? longint'(ub) - 2 * lim : longint'(ub);
        r  = op ? sa - sb - longint'(cin) : sa + sb + longint'(cin);
        e.ovf = (r >= lim) || (r < -lim);
        e.a   = a;
        e.b   = b;
        e.acc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (bus16.out_valid && bus16.out_ready) begin
            if (q16.size() == 0) begin
                check("extra16", 64'(q16.size()), 64'd1);
            end else begin
                m16 = q16.pop_front();
                check("sum16", 64'(bus16.sum), 64'(m16.sum[15:0]));
                check("cout16", 64'(bus16.cout), 64'(m16.cout));
                check("ovf16", 64'(bus16.ovf), 64'(m16.ovf));
                if (lat16) check("lat16", 64'(cyc - m16.acc), 64'd4);
                $display("w16 a=%h b=%h sum=%h cout=%b ovf=%b", m16.a[15:0], m16.b[15:0],
                         bus16.sum, bus16.cout, bus16.ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (bus32.out_valid && bus32.out_ready) begin
            if (q32.size() == 0) begin
                check("extra32", 64'(q32.size()), 64'd1);
            end else begin
                m32 = q32.pop_front();
                check("sum32", 64'(bus32.sum), 64'(m32.sum));
                check("cout32", 64'(bus32.cout), 64'(m32.cout));
                check("ovf32", 64'(bus32.ovf), 64'(m32.ovf));
                $display("w32 a=%h b=%h sum=%h cout=%b ovf=%b", m32.a, m32.b,
                         bus32.sum, bus32.cout, bus32.ovf);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send16x(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic op, input logic [15:0] ws, input logic wc, input logic wo);
        exp_t e;
        bit   got;
        e.a = 32'(a); e.b = 32'(b); e.sum = 32'(ws); e.cout = wc; e.ovf = wo; e.acc = 0;
        bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.op_sub = op; bus16.in_valid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (bus16.in_ready) begin
                e.acc = cyc + 1;
                q16.push_back(e);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus16.in_valid = 1'b0;
        check("accept16", 64'(got), 64'd1);
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic op);
        exp_t e;
        e = model(16, 32'(a), 32'(b), cin, op);
        send16x(a, b, cin, op, e.sum[15:0], e.cout, e.ovf);
    endtask

    task automatic drain(input bit wide);
        for (int t = 0; t < 400; t++) begin
            if ((wide ? q32.size() : q16.size()) == 0) break;
            @(negedge clk);
        end
        check(wide ? "drain32" : "drain16", 64'(wide ? q32.size() : q16.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic rand16(input int n);
        int   sent = 0;
        exp_t e;
        while (sent < n) begin
            bus16.out_ready = ($urandom % 4) != 0;
            bus16.in_valid  = ($urandom % 4) != 0;
            bus16.a      = (($urandom % 8) == 0) ? 16'hFFFF : 16'($urandom);
            bus16.b      = (($urandom % 8) == 0) ? 16'h8000 : 16'($urandom);
            bus16.cin    = 1'($urandom);
            bus16.op_sub = 1'($urandom);
            @(negedge clk);
            if (bus16.in_valid && bus16.in_ready) begin
                e = model(16, 32'(bus16.a), 32'(bus16.b), bus16.cin, bus16.op_sub);
                q16.push_back(e);
                sent++;
            end
            @(posedge clk);
            #1;
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        drain(1'b0);
    endtask

    task automatic rand32(input int n);
        int   sent = 0;
        exp_t e;
        while (sent < n) begin
            bus32.out_ready = ($urandom % 4) != 0;
            bus32.in_valid  = ($urandom % 4) != 0;
            bus32.a      = (($urandom % 8) == 0) ? 32'h7FFF_FFFF : $urandom;
            bus32.b      = (($urandom % 8) == 0) ? 32'hFFFF_FFFF : $urandom;
            bus32.cin    = 1'($urandom);
            bus32.op_sub = 1'($urandom);
            @(negedge clk);
            if (bus32.in_valid && bus32.in_ready) begin
                e = model(32, bus32.a, bus32.b, bus32.cin, bus32.op_sub);
                q32.push_back(e);
                sent++;
            end
            @(posedge clk);
            #1;
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        drain(1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
        bus16.op_sub = 1'b0; bus16.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0;
        bus32.op_sub = 1'b0; bus32.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus16.out_valid), 64'd0);
        check("rst_sum", 64'(bus16.sum), 64'd0);
        check("rst_cout", 64'(bus16.cout), 64'd0);
        check("rst_ovf", 64'(bus16.ovf), 64'd0);
        check("rst_out_valid32", 64'(bus32.out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(bus16.in_ready), 64'd1);
        check("rst_in_ready32", 64'(bus32.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Carry chain, overflow and subtract corners with fixed expectations
        lat16 = 1'b1;
        send16x(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send16x(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send16x(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send16x(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        send16x(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        drain(1'b0);

        // Back-to-back streaming: eight accepts, each result exactly four cycles later
        for (int i = 0; i < 8; i++) send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        drain(1'b0);
        lat16 = 1'b0;

        // Backpressure: head result must hold and in_ready must drop for three cycles
        bus16.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        for (int t = 0; t < 20 && !bus16.out_valid; t++) @(negedge clk);
        check("bp_out_valid", 64'(bus16.out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", 64'(bus16.in_ready), 64'd0);
            check("bp_sum_hold", 64'(bus16.sum), 64'(q16[0].sum[15:0]));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus16.out_ready = 1'b1;
        drain(1'b0);

        // Reset with three operations in flight: all discarded
        for (int i = 0; i < 3; i++) send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus16.out_valid), 64'd0);
        check("midrst_sum", 64'(bus16.sum), 64'd0);
        q16.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 64'(bus16.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Random streams on both widths with random backpressure
        fork
            rand16(10000);
            rand32(10000);
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
